// File: rtl/sync_ram_pkg.sv
// rtl/sync_ram_pkg.sv - shared constants and state type for sync_ram_be
package sync_ram_pkg;

  localparam int LANE_W        = 8;

  localparam int WM_NOCHANGE   = 0;
  localparam int WM_READFIRST  = 1;
  localparam int WM_WRITEFIRST = 2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/sync_ram_be_if.sv
// rtl/sync_ram_be_if.sv - access and status bundle between a requester and sync_ram_be
interface sync_ram_be_if
  import sync_ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);

  logic                       req;
  logic                       wr;
  logic [ADDR_W-1:0]          addr;
  logic [DATA_W/LANE_W-1:0]   be;
  logic [DATA_W-1:0]          din;
  logic                       clr;
  logic                       ready;
  logic                       init_busy;
  logic [DATA_W-1:0]          dout;
  logic                       dout_vld;

  modport master (
    output req, wr, addr, be, din, clr,
    input  ready, init_busy, dout, dout_vld
  );

  modport slave (
    input  req, wr, addr, be, din, clr,
    output ready, init_busy, dout, dout_vld
  );

endinterface

// File: rtl/sync_ram_init_fsm.sv
// rtl/sync_ram_init_fsm.sv - zero-fill sequencer owning ready/init_busy and the fill write port
module sync_ram_init_fsm
  import sync_ram_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  output logic              ready,
  output logic              init_busy,
  output logic              fill_we,
  output logic [ADDR_W-1:0] fill_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        if (clr) begin
          cnt_d = '0;
        end else if (cnt_q == LAST_ADDR) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (clr) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // Decoded straight from the state flop so the outputs stay glitch-free registers.
  assign ready     = (state_q == ST_RUN);
  assign init_busy = (state_q == ST_CLEAR);
  assign fill_we   = (state_q == ST_CLEAR);
  assign fill_addr = cnt_q;

endmodule

// File: rtl/sync_ram_be.sv
// rtl/sync_ram_be.sv - parametrised single-port RAM with byte lanes, zero-fill and 1/2-cycle reads
module sync_ram_be
  import sync_ram_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int RD_LAT  = 1,
  parameter int WR_MODE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  sync_ram_be_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int LANES = DATA_W / LANE_W;

  generate
    if (DATA_W < LANE_W || (DATA_W % LANE_W) != 0) begin : g_bad_width
      $fatal(1, "sync_ram_be: DATA_W must be a positive multiple of 8");
    end
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
      $fatal(1, "sync_ram_be: RD_LAT must be 1 or 2");
    end
    if (WR_MODE != WM_NOCHANGE && WR_MODE != WM_READFIRST && WR_MODE != WM_WRITEFIRST) begin : g_bad_mode
      $fatal(1, "sync_ram_be: WR_MODE must be 0, 1 or 2");
    end
  endgenerate

  logic [DATA_W-1:0] mem [DEPTH];

  logic              fill_we;
  logic [ADDR_W-1:0] fill_addr;
  logic              accept;
  logic              user_we;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [LANES-1:0]  wbe;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] merged_word;
  logic [DATA_W-1:0] ret_word;
  logic              ret_vld;

  sync_ram_init_fsm #(
    .ADDR_W (ADDR_W)
  ) u_init (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (bus.clr),
    .ready     (bus.ready),
    .init_busy (bus.init_busy),
    .fill_we   (fill_we),
    .fill_addr (fill_addr)
  );

  // ready is low throughout the fill, so user writes and fill writes never coincide.
  assign accept   = bus.req && bus.ready;
  assign user_we  = accept && bus.wr;
  assign we       = fill_we || user_we;
  assign waddr    = fill_we ? fill_addr : bus.addr;
  assign wbe      = fill_we ? '1 : bus.be;
  assign wdata    = fill_we ? '0 : bus.din;
  assign old_word = mem[bus.addr];

  always_comb begin
    merged_word = old_word;
    for (int i = 0; i < LANES; i++) begin
      if (bus.be[i]) begin
        merged_word[i*LANE_W +: LANE_W] = bus.din[i*LANE_W +: LANE_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (we && wbe[i]) begin
        mem[waddr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
      end
    end
  end

  assign ret_vld  = accept && (!bus.wr || WR_MODE != WM_NOCHANGE);
  assign ret_word = (bus.wr && WR_MODE == WM_WRITEFIRST) ? merged_word : old_word;

  generate
    if (RD_LAT == 1) begin : g_lat1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          bus.dout     <= '0;
          bus.dout_vld <= 1'b0;
        end else begin
          bus.dout_vld <= ret_vld;
          if (ret_vld) begin
            bus.dout <= ret_word;
          end
        end
      end
    end else begin : g_lat2
      logic [DATA_W-1:0] pipe_dat;
      logic              pipe_vld;

      // Stage registers are not touched by clr, so in-flight reads drain normally.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pipe_dat     <= '0;
          pipe_vld     <= 1'b0;
          bus.dout     <= '0;
          bus.dout_vld <= 1'b0;
        end else begin
          pipe_vld     <= ret_vld;
          bus.dout_vld <= pipe_vld;
          if (ret_vld) begin
            pipe_dat <= ret_word;
          end
          if (pipe_vld) begin
            bus.dout <= pipe_dat;
          end
        end
      end
    end
  endgenerate

endmodule
